// File: rtl/vpu_reduction_combiner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_reduction_combiner_pkg
//  Description : Shared types and sizes for the VPU reduction combiner slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package vpu_reduction_combiner_pkg;

    localparam int EXEC_CNT      = 4;
    localparam int OPERAND_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4
    } red_comb_state_t;

    typedef enum logic {
        RED_SUM = 1'b0,
        RED_MAX = 1'b1
    } red_op_t;

    typedef struct packed {
        logic fp_sum_r;
        logic fp_max_r;
    } vpu_fp_req_t;

    typedef struct packed {
        vpu_fp_req_t fp_req;
    } vpu_exec_req_t;

    // Sum only when exactly the sum bit is set; anything ambiguous folds as max.
    function automatic red_op_t decode_red_op(input vpu_exec_req_t req);
        return (req.fp_req.fp_sum_r && !req.fp_req.fp_max_r) ? RED_SUM : RED_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_fp_add2.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_fp_add2
//  Description : bf16 two-operand adder, one-cycle latency, truncating,
//                zero exponent treated as zero, overflow saturates to inf.
//  Revision    : 1.0 - initial release
// ============================================================================
module vpu_fp_add2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] operand_0_i,
    input  logic [15:0] operand_1_i,
    input  logic [7:0]  sub_i,
    output logic        done_o,
    output logic [15:0] result_o
);

    logic [15:0]       w_b;
    logic [15:0]       w_big;
    logic [15:0]       w_sml;
    logic [10:0]       w_m_big;
    logic [10:0]       w_m_sml;
    logic [10:0]       w_m_al;
    logic [7:0]        w_shamt;
    logic [11:0]       w_sum;
    logic [3:0]        w_lead;
    logic              w_found;
    logic [6:0]        w_frac;
    logic signed [9:0] w_exp;
    logic [15:0]       w_res;

    // Align smaller magnitude to larger, add/subtract, renormalise on the leading one.
    always_comb begin
        w_b = {operand_1_i[15] ^ (|sub_i), operand_1_i[14:0]};
        if (operand_0_i[14:0] >= w_b[14:0]) begin
            w_big = operand_0_i;
            w_sml = w_b;
        end else begin
            w_big = w_b;
            w_sml = operand_0_i;
        end
        w_m_big = (w_big[14:7] == 8'd0) ? 11'd0 : {1'b1, w_big[6:0], 3'b000};
        w_m_sml = (w_sml[14:7] == 8'd0) ? 11'd0 : {1'b1, w_sml[6:0], 3'b000};
        w_shamt = w_big[14:7] - w_sml[14:7];
        w_m_al  = (w_shamt > 8'd10) ? 11'd0 : (w_m_sml >> w_shamt);
        if (w_big[15] == w_sml[15]) w_sum = {1'b0, w_m_big} + {1'b0, w_m_al};
        else                        w_sum = {1'b0, w_m_big} - {1'b0, w_m_al};
        w_lead  = 4'd0;
        w_found = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (!w_found && w_sum[i]) begin
                w_lead  = 4'(i);
                w_found = 1'b1;
            end
        end
        w_frac = 7'((w_sum << (4'd11 - w_lead)) >> 4);
        w_exp  = $signed({2'b00, w_big[14:7]}) + $signed({6'd0, w_lead}) - 10'sd10;
        if (!w_found || (w_exp <= 10'sd0)) w_res = 16'h0000;
        else if (w_exp >= 10'sd255)        w_res = {w_big[15], 8'hFF, 7'd0};
        else                               w_res = {w_big[15], w_exp[7:0], w_frac};
    end

    // Register result and raise done one cycle after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_o   <= 1'b0;
            result_o <= 16'h0000;
        end else begin
            done_o <= start_i;
            if (start_i) result_o <= w_res;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vpu_fp_max2.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_fp_max2
//  Description : bf16 two-operand maximum, one-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module vpu_fp_max2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] operand_0_i,
    input  logic [15:0] operand_1_i,
    output logic        done_o,
    output logic [15:0] result_o
);

    // Maps sign-magnitude onto an unsigned key that orders like the FP value.
    function automatic logic [15:0] order_key(input logic [15:0] v);
        return v[15] ? ~v : (v ^ 16'h8000);
    endfunction

    logic [15:0] w_res;

    assign w_res = (order_key(operand_0_i) >= order_key(operand_1_i)) ? operand_0_i : operand_1_i;

    // Register result and raise done one cycle after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_o   <= 1'b0;
            result_o <= 16'h0000;
        end else begin
            done_o <= start_i;
            if (start_i) result_o <= w_res;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vpu_red_partial_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_red_partial_fifo
//  Description : Small synchronous FIFO buffering per-exec partial scalars.
//  Revision    : 1.0 - initial release
// ============================================================================
module vpu_red_partial_fifo
    import vpu_reduction_combiner_pkg::*;
#(
    parameter  int DEPTH = EXEC_CNT,
    parameter  int WIDTH = OPERAND_WIDTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_i) r_mem[r_wr_ptr] <= din_i;
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/vpu_reduction_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_reduction_combiner
//  Description : Folds EXEC_CNT per-exec partial scalars (sum or max) in
//                arrival order into one result, handed off via valid/ready.
//                Define VPU_RED_COMB_PROT_CHK_EN to build the sticky
//                protocol-error detector driving err_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module vpu_reduction_combiner
    import vpu_reduction_combiner_pkg::*;
#(
    parameter int EXEC_CNT      = vpu_reduction_combiner_pkg::EXEC_CNT,
    parameter int OPERAND_WIDTH = vpu_reduction_combiner_pkg::OPERAND_WIDTH,
    parameter int FIFO_DEPTH    = EXEC_CNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  vpu_exec_req_t            op_func_i,
    input  logic                     partial_valid_i,
    input  logic [OPERAND_WIDTH-1:0] partial_i,
    output logic                     busy_o,
    output logic                     result_valid_o,
    output logic [OPERAND_WIDTH-1:0] result_o,
    input  logic                     result_ready_i,
    output logic                     err_o
);

    localparam int CNT_W  = $clog2(EXEC_CNT + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_exec_cnt = CNT_W'(EXEC_CNT);

    red_comb_state_t          r_state;
    red_comb_state_t          w_state_nxt;
    red_op_t                  r_op;
    logic [OPERAND_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]         r_rcv_cnt;
    logic [CNT_W-1:0]         r_cmb_cnt;

    logic                     w_in_flight;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_first_load;
    logic                     w_fp_load;
    logic                     w_clear;
    logic                     w_fifo_empty;
    logic [FCNT_W-1:0]        w_fifo_count;
    logic [OPERAND_WIDTH-1:0] w_fifo_head;
    logic                     w_add_done;
    logic                     w_max_done;
    logic [15:0]              w_add_res;
    logic [15:0]              w_max_res;
    logic                     w_fp_done;
    logic [15:0]              w_fp_res;

    // Partials count while a reduction is open and not full, or alongside the start itself.
    assign w_in_flight = (r_state == COLLECT) || (r_state == ISSUE) || (r_state == WAIT);
    assign w_accept    = partial_valid_i &&
                         ((w_in_flight && (r_rcv_cnt < c_exec_cnt)) || ((r_state == IDLE) && start_i));

    vpu_red_partial_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OPERAND_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_accept),
        .din_i   (partial_i),
        .pop_i   (w_pop),
        .dout_o  (w_fifo_head),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    vpu_fp_add2 u_add (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_issue && (r_op == RED_SUM)),
        .operand_0_i (r_acc),
        .operand_1_i (w_fifo_head),
        .sub_i       (8'h00),
        .done_o      (w_add_done),
        .result_o    (w_add_res)
    );

    vpu_fp_max2 u_max (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_issue && (r_op == RED_MAX)),
        .operand_0_i (r_acc),
        .operand_1_i (w_fifo_head),
        .done_o      (w_max_done),
        .result_o    (w_max_res)
    );

    assign w_fp_done = (r_op == RED_SUM) ? w_add_done : w_max_done;
    assign w_fp_res  = (r_op == RED_SUM) ? w_add_res  : w_max_res;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath strobes; the first partial seeds acc without an FP op.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_first_load = 1'b0;
        w_fp_load    = 1'b0;
        w_clear      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) w_state_nxt = COLLECT;
            end
            COLLECT: begin
                if (!w_fifo_empty) begin
                    if (r_cmb_cnt == '0) begin
                        w_pop        = 1'b1;
                        w_first_load = 1'b1;
                        if (c_exec_cnt == CNT_W'(1))                     w_state_nxt = DONE;
                        else if ((w_fifo_count > FCNT_W'(1)) || w_accept) w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_pop       = 1'b1;
                w_issue     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_fp_done) begin
                    w_fp_load = 1'b1;
                    if ((r_cmb_cnt + CNT_W'(1)) == c_exec_cnt) w_state_nxt = DONE;
                    else if (!w_fifo_empty || w_accept)         w_state_nxt = ISSUE;
                    else                                        w_state_nxt = COLLECT;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operation latch, accumulator and the received/combined counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= RED_MAX;
            r_acc     <= '0;
            r_rcv_cnt <= '0;
            r_cmb_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && start_i) r_op <= decode_red_op(op_func_i);
            if (w_clear) begin
                r_rcv_cnt <= '0;
                r_cmb_cnt <= '0;
            end else begin
                if (w_accept) r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
                if (w_first_load) begin
                    r_acc     <= w_fifo_head;
                    r_cmb_cnt <= CNT_W'(1);
                end else if (w_fp_load) begin
                    r_acc     <= w_fp_res;
                    r_cmb_cnt <= r_cmb_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy_o         = (r_state != IDLE);
    assign result_valid_o = (r_state == DONE);
    assign result_o       = r_acc;

`ifdef VPU_RED_COMB_PROT_CHK_EN
    logic r_err;
    logic w_prot_viol;

    assign w_prot_viol = (partial_valid_i && (((r_state == IDLE) && !start_i) || (r_state == DONE))) ||
                         (partial_valid_i && (r_rcv_cnt == c_exec_cnt)) ||
                         (start_i && (r_state != IDLE));

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_err <= 1'b0;
        else if (w_prot_viol) r_err <= 1'b1;
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vpu_reduction_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vpu_reduction_combiner
//  Description : Self-checking bench for vpu_reduction_combiner: real-valued
//                reference fold checked every cycle, plus literal results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vpu_reduction_combiner;
    import vpu_reduction_combiner_pkg::*;

    localparam int N = vpu_reduction_combiner_pkg::EXEC_CNT;
`ifdef VPU_RED_COMB_PROT_CHK_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    vpu_exec_req_t op_func = '0;
    logic          pvalid = 1'b0;
    logic [15:0]   partial = 16'h0000;
    logic          result_ready = 1'b0;
    logic          busy_o;
    logic          result_valid_o;
    logic [15:0]   result_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vpu_reduction_combiner dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .op_func_i       (op_func),
        .partial_valid_i (pvalid),
        .partial_i       (partial),
        .busy_o          (busy_o),
        .result_valid_o  (result_valid_o),
        .result_o        (result_o),
        .result_ready_i  (result_ready),
        .err_o           (err_o)
    );

    // bf16 -> real through the IEEE double bit layout (exact for normal values).
    function automatic real bf2r(input logic [15:0] b);
        logic [63:0] d;
        if (b[14:7] == 8'd0) return 0.0;
        d = {b[15], 11'(int'(b[14:7]) - 127 + 1023), b[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: which partials were accepted, which op, error flag.
    logic m_busy = 1'b0;
    logic m_sum  = 1'b0;
    logic m_err  = 1'b0;
    int   m_rcv  = 0;
    real  m_p [N];

    function automatic real fold_exp();
        real a;
        a = m_p[0];
        for (int i = 1; i < N; i++) a = m_sum ? (a + m_p[i]) : ((m_p[i] > a) ? m_p[i] : a);
        return a;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_rcv  <= 0;
            m_err  <= 1'b0;
            m_sum  <= 1'b0;
        end else begin
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_sum  <= op_func.fp_req.fp_sum_r && !op_func.fp_req.fp_max_r;
                    if (pvalid) begin
                        m_p[0] <= bf2r(partial);
                        m_rcv  <= 1;
                    end
                end
            end else begin
                if (pvalid && (m_rcv < N)) begin
                    m_p[m_rcv] <= bf2r(partial);
                    m_rcv      <= m_rcv + 1;
                end
                if (result_valid_o && result_ready) begin
                    m_busy <= 1'b0;
                    m_rcv  <= 0;
                end
            end
            if (PROT && ((pvalid && !m_busy && !start) || (pvalid && m_busy && (m_rcv == N)) ||
                         (start && m_busy)))
                m_err <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("err", 32'(err_o), 32'(m_err));
        if (!m_busy) begin
            chk("valid_when_idle", 32'(result_valid_o), 32'd0);
        end else if (result_valid_o) begin
            n_checks++;
            if ((m_rcv != N) || (bf2r(result_o) != fold_exp())) begin
                n_fail++;
                $display("FAIL result: got %h (%f) after %0d partials, expected %f after %0d partials",
                         result_o, bf2r(result_o), m_rcv, fold_exp(), N);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic s, input logic m);
        op_func.fp_req.fp_sum_r = s;
        op_func.fp_req.fp_max_r = m;
    endtask

    task automatic send(input logic st, input logic [15:0] p);
        start   = st;
        pvalid  = 1'b1;
        partial = p;
        tick();
        start   = 1'b0;
        pvalid  = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; (i < limit) && !result_valid_o; i++) tick();
        chk("valid_timeout", 32'(result_valid_o), 32'd1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("busy_after_handshake", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq_sum [4];
        seq_sum = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};

        tick();
        tick();
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_valid", 32'(result_valid_o), 32'd0);
        chk("reset_result", 32'(result_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        tick();

        // Sum of 1,2,3,4 back to back, first partial alongside start; then backpressure.
        set_op(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(i == 0, seq_sum[i]);
        wait_valid(40);
        chk("sum_result", 32'(result_o), 32'h4120);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(result_valid_o), 32'd1);
            chk("bp_result", 32'(result_o), 32'h4120);
        end
        handshake();

        // Max of -1,3,2,0.5 spaced 5 cycles; a stray sum start mid-way is ignored.
        set_op(1'b0, 1'b1);
        send(1'b1, 16'hBF80);
        for (int k = 1; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                if ((k == 2) && (j == 1)) begin
                    set_op(1'b1, 1'b0);
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    set_op(1'b0, 1'b1);
                end else begin
                    tick();
                end
            end
            send(1'b0, (k == 1) ? 16'h4040 : (k == 2) ? 16'h4000 : 16'h3F00);
        end
        wait_valid(40);
        chk("max_result", 32'(result_o), 32'h4040);
        chk("err_after_stray_start", 32'(err_o), 32'(PROT));
        handshake();

        // Neither op bit set folds as max; a fifth partial is dropped.
        set_op(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(i == 0, seq_sum[i]);
        send(1'b0, 16'h4100);
        wait_valid(40);
        chk("default_max_result", 32'(result_o), 32'h4080);
        chk("err_after_extra", 32'(err_o), 32'(PROT));
        handshake();

        // Next reduction must not see the dropped partial: 2+2+2+2 = 8.
        set_op(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(i == 0, 16'h4000);
        wait_valid(40);
        chk("sum_after_drop", 32'(result_o), 32'h4100);
        handshake();

        // Reset while the first FP op is outstanding.
        send(1'b1, 16'h3F80);
        send(1'b0, 16'h3F80);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send(i == 0, 16'h3F80);
        wait_valid(40);
        chk("sum_after_reset", 32'(result_o), 32'h4080);
        handshake();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
